// File: rtl/alu_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_arb_pkg
// Purpose  : Shared definitions for the ALU arbiter: FSM state encoding,
//            default datapath widths and the watchdog width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package alu_arb_pkg;

  localparam int NB_DATA_DEF = 8;
  localparam int NB_OP_DEF   = 6;

  // One-hot encoded arbiter states
  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_EXEC = 3'b010,
    ST_RESP = 3'b100
  } state_e;

  // Watchdog counter width: just enough to hold TIMEOUT-1 without wrapping.
  function automatic int wdog_width(input int timeout);
    return (timeout > 2) ? $clog2(timeout) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational rotating-priority arbiter. The search starts at
//            the requester after the last grant and wraps modulo N_REQ.
// Ports    : req_i   - request vector
//            last_i  - index of the previously granted requester
//            gnt_o   - one-hot grant (0 when nothing requests)
//            idx_o   - index of the granted requester
//            any_o   - at least one requester is granted
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDXW  = 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDXW-1:0]  last_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDXW-1:0]  idx_o,
  output logic             any_o
);

  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic [IDXW:0]      w_shift;
  int                 w_cand;

  // Rotate the request vector so that bit 0 is the requester right after
  // last_i; the first set bit then wins.
  always_comb begin
    w_shift = {1'b0, last_i} + (IDXW+1)'(1);
    w_dbl   = {req_i, req_i} >> w_shift;
    w_rot   = w_dbl[N_REQ-1:0];
    w_cand  = 0;
    gnt_o   = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!any_o && w_rot[j]) begin
        any_o  = 1'b1;
        w_cand = int'(last_i) + 1 + j;
        if (w_cand >= N_REQ) begin
          w_cand = w_cand - N_REQ;
        end
        idx_o = w_cand[IDXW-1:0];
      end
    end
    if (any_o) begin
      gnt_o = {{(N_REQ-1){1'b0}}, 1'b1} << idx_o;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Shares one ALU between N_REQ requesters with round-robin
//            fairness, sequences the ALU start/valid handshake, guards it
//            with a watchdog and returns the result to the owner only.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            req_valid_i/a/b/op  - packed per-requester requests
//            req_ready_o         - one-hot grant (IDLE only)
//            rsp_valid_o/data/timeout - one-cycle response to the owner
//            busy_o              - EXEC or RESP
//            alu_start_o/a/b/op  - ALU command, held during EXEC
//            alu_result_i/valid_i - ALU answer
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_OP   = NB_OP_DEF,
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid_i,
  input  logic [N_REQ*NB_DATA-1:0] req_a_i,
  input  logic [N_REQ*NB_DATA-1:0] req_b_i,
  input  logic [N_REQ*NB_OP-1:0]   req_op_i,
  output logic [N_REQ-1:0]         req_ready_o,
  output logic [N_REQ-1:0]         rsp_valid_o,
  output logic [NB_DATA-1:0]       rsp_data_o,
  output logic                     rsp_timeout_o,
  output logic                     busy_o,
  output logic                     alu_start_o,
  output logic [NB_DATA-1:0]       alu_a_o,
  output logic [NB_DATA-1:0]       alu_b_o,
  output logic [NB_OP-1:0]         alu_op_o,
  input  logic [NB_DATA-1:0]       alu_result_i,
  input  logic                     alu_valid_i
);

  localparam int             IDXW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int             WDW     = wdog_width(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [IDXW-1:0] LAST_RST = IDXW'(N_REQ - 1);

  state_e               state_q, state_d;
  logic [NB_DATA-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic [NB_OP-1:0]     op_q, op_d;
  logic [IDXW-1:0]      idx_q, idx_d, last_q, last_d;
  logic [WDW-1:0]       wd_q, wd_d;
  logic                 to_q, to_d;

  logic [N_REQ-1:0]     w_gnt;
  logic [IDXW-1:0]      w_idx;
  logic                 w_any;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDXW  (IDXW)
  ) u_rr (
    .req_i  (req_valid_i),
    .last_i (last_q),
    .gnt_o  (w_gnt),
    .idx_o  (w_idx),
    .any_o  (w_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      last_q  <= LAST_RST;
      wd_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    idx_d   = idx_q;
    last_d  = last_q;
    wd_d    = wd_q;
    to_d    = to_q;
    case (state_q)
      ST_IDLE: begin
        // The arbiter only grants valid requesters, so any grant is a transfer.
        if (w_any) begin
          for (int i = 0; i < N_REQ; i++) begin
            if (w_idx == IDXW'(i)) begin
              a_d  = req_a_i[i*NB_DATA +: NB_DATA];
              b_d  = req_b_i[i*NB_DATA +: NB_DATA];
              op_d = req_op_i[i*NB_OP +: NB_OP];
            end
          end
          idx_d   = w_idx;
          last_d  = w_idx;
          wd_d    = '0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // alu_valid takes precedence over the watchdog terminal count.
        if (alu_valid_i) begin
          res_d   = alu_result_i;
          to_d    = 1'b0;
          state_d = ST_RESP;
        end else if (wd_q == WD_LAST) begin
          res_d   = '0;
          to_d    = 1'b1;
          state_d = ST_RESP;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // req_ready is combinational, so it is also gated by reset to keep all
  // outputs low while rst_n is asserted.
  assign req_ready_o   = (rst_n && (state_q == ST_IDLE)) ? w_gnt : '0;
  assign busy_o        = (state_q == ST_EXEC) || (state_q == ST_RESP);
  assign alu_start_o   = (state_q == ST_EXEC);
  assign alu_a_o       = a_q;
  assign alu_b_o       = b_q;
  assign alu_op_o      = op_q;
  assign rsp_data_o    = (state_q == ST_RESP) ? res_q : '0;
  assign rsp_timeout_o = (state_q == ST_RESP) && to_q;

  always_comb begin
    rsp_valid_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if ((state_q == ST_RESP) && (idx_q == IDXW'(i))) begin
        rsp_valid_o[i] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single ALU between N_REQ requesters, for example the UART command interface and a debug/self-test port.
- Accepts one operation at a time with round-robin fairness.
- Sequences the ALU start/valid handshake, with a watchdog against a missing alu_valid.
- Returns the result to the granted requester only.

Parameters:
NB_DATA, 8, operand/result width
NB_OP, 6, ALU opcode width
N_REQ, 2, number of requesters (2..4)
TIMEOUT, 16, max cycles in EXEC waiting for alu_valid (>=2)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low; 0 = reset
req_valid  input  N_REQ  request pending, per requester
req_a  input  N_REQ*NB_DATA  operand A, requester i at [i*NB_DATA +: NB_DATA]
req_b  input  N_REQ*NB_DATA  operand B, same packing
req_op  input  N_REQ*NB_OP  opcode, requester i at [i*NB_OP +: NB_OP]
req_ready  output  N_REQ  one-hot grant; a transfer occurs on a clock edge with req_valid[i] & req_ready[i]
rsp_valid  output  N_REQ  one-cycle pulse to the owning requester
rsp_data  output  NB_DATA  result; valid only while any rsp_valid bit is high
rsp_timeout  output  1  high together with rsp_valid when the ALU never answered
busy  output  1  high in EXEC and RESP
alu_start  output  1  to ALU, level while in EXEC
alu_a  output  NB_DATA  to ALU, from latched operand register
alu_b  output  NB_DATA  to ALU, from latched operand register
alu_op  output  NB_OP  to ALU, from latched opcode register
alu_result  input  NB_DATA  from ALU
alu_valid  input  1  from ALU, result valid

Behaviour:
Reset:
- reset=0 asynchronously forces state=IDLE.
- Clears operand/opcode/result registers, watchdog counter and timeout flag.
- Sets last_grant=N_REQ-1, so requester 0 wins first.
- All outputs are 0 during reset, including alu_*, rsp_*, req_ready and busy.
- Reset mid-operation drops the in-flight request with no rsp_valid.

FSM: one-hot IDLE, EXEC, RESP.

IDLE:
- req_ready is combinational: one-hot for the first requester with req_valid set, searching from last_grant+1 modulo N_REQ upward.
- req_ready is 0 if no requester is valid.
- On a transfer edge: latch that requester's a/b/op, record grant index, set last_grant=grant, clear watchdog, go EXEC.
- A requester may drop req_valid before being granted; this has no side effects.

EXEC:
- alu_start=1; alu_a, alu_b and alu_op are driven from the latched registers, stable throughout.
- Watchdog increments every EXEC cycle.
- On alu_valid=1: latch alu_result, clear timeout flag, go RESP.
- Else, when the watchdog reaches TIMEOUT-1: latch result=0, set timeout flag, go RESP.
- alu_valid and the watchdog terminal count in the same cycle: alu_valid wins, no timeout.

RESP:
- rsp_valid[grant]=1 for exactly one cycle; rsp_data = latched result; rsp_timeout = flag.
- alu_start=0. Go IDLE.

General rules:
- alu_valid outside EXEC is ignored.
- req_ready is 0 outside IDLE.
- Minimum latency: transfer edge, EXEC (alu_valid same cycle), RESP next cycle, then IDLE. Peak throughput is 1 op per 3 cycles.
- A requester holding req_valid continuously still yields to the other valid requesters (round-robin).
- Watchdog width is $clog2(TIMEOUT); it must not wrap.

Decomposition:
- Package alu_arb_pkg holds:
  - state encodings ST_IDLE=3'b001, ST_EXEC=3'b010, ST_RESP=3'b100;
  - default widths NB_DATA/NB_OP;
  - the function computing the watchdog width.
- One natural sub-module, rr_arbiter: combinational rotating-priority grant from req_valid and last_grant, outputting one-hot grant plus index.
- The operand mux, FSM and watchdog stay in alu_arbiter.

Test Plan:
- Single request: after reset, req 0 valid with a=8'h12, b=8'h34, op=6'h20; ALU model asserts valid 2 cycles after start with 8'h46. Expect alu_start high 2 cycles, rsp_valid=2'b01 for 1 cycle, rsp_data=8'h46, rsp_timeout=0.
- Round-robin: req 0 and req 1 both held valid for 4 operations. Expect grants in order 0,1,0,1, each rsp_valid on the matching bit with that requester's result.
- Timeout: req 1 issued; ALU never asserts valid. Expect alu_start high exactly 16 cycles, then rsp_valid=2'b10, rsp_data=8'h00, rsp_timeout=1; next request is served normally.
- Simultaneous: alu_valid coincides with watchdog terminal count (valid at cycle 16). Expect result latched, rsp_timeout=0.
- Reset mid-op: reset=0 asserted during EXEC. Expect immediate IDLE, outputs 0, no rsp_valid; after release req 0 is granted first.
- Stray valid: alu_valid pulsed in IDLE and RESP. Expect no state change and no extra rsp_valid.
